mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous single-port 64x32 RAM between the core instruction fetch port,
//  the core data port and a write-only program loader. After reset a LOAD phase gives the
//  loader exclusive access; RUN phase arbitrates fetch vs data with a starvation guard.
//  Core-side stall is driven whenever a core request is not granted in its cycle.
// PARAMETERS
//  AW           6   address width (word addresses)
//  DW           32  data width
//  STARVE_LIMIT 4   consecutive denied fetch cycles after which fetch beats data
// PORTS
//  clk       in  1   clock
//  rst       in  1   reset rst, synchronous, active-high
//  ld_req    in  1   loader write request (LOAD phase only)
//  ld_addr   in  AW  loader write address
//  ld_wdata  in  DW  loader write data
//  ld_done   in  1   1-cycle pulse: loading finished, enter RUN
//  ld_gnt    out 1   loader write accepted this cycle
//  i_req     in  1   fetch read request
//  i_addr    in  AW  fetch address
//  i_gnt     out 1   fetch accepted this cycle
//  i_rvalid  out 1   fetch data valid (1 cycle after i_gnt)
//  i_rdata   out DW  fetch data
//  d_req     in  1   data request
//  d_we      in  1   1=write, 0=read
//  d_addr    in  AW  data address
//  d_wdata   in  DW  data write value
//  d_gnt     out 1   data access accepted this cycle
//  d_rvalid  out 1   data read valid (1 cycle after read d_gnt; never for writes)
//  d_rdata   out DW  data read value
//  ram_en    out 1   RAM access enable
//  ram_we    out 1   RAM write enable
//  ram_addr  out AW  RAM address
//  ram_wdata out DW  RAM write data
//  ram_rdata in  DW  RAM read data, valid 1 cycle after ram_en&!ram_we
//  core_stall out 1  (i_req&!i_gnt)|(d_req&!d_gnt)
//  phase_run out 1   1 in RUN state
// BEHAVIOUR
//  - FSM: LOAD (reset state) -> RUN on ld_done. RUN is terminal until rst. ld_done in RUN ignored.
//  - LOAD: ld_gnt=ld_req; i_gnt=d_gnt=0; RAM write of ld_addr/ld_wdata when ld_req.
//  - RUN: ld_gnt=0. Grants combinational from requests + registered starve counter:
//    data wins over fetch unless starve_cnt==STARVE_LIMIT, then fetch wins. At most one grant/cycle.
//  - starve_cnt (registered, width clog2(STARVE_LIMIT+1)): +1 when i_req&!i_gnt (saturates at
//    STARVE_LIMIT); cleared when i_gnt or !i_req or in LOAD.
//  - Requester holds req/addr/data stable until its gnt; a grant consumes the request that cycle.
//  - RAM command (ram_en/we/addr/wdata) is the granted request, combinational; ram_en=0 if none.
//  - i_rvalid/d_rvalid registered: set the cycle after a read grant of that port, else 0.
//    i_rdata=d_rdata=ram_rdata (pass-through; meaningful only with the port's rvalid).
//  - Latency: read grant cycle N -> rvalid+data cycle N+1. Back-to-back grants every cycle allowed.
//  - Data write then read same address on consecutive cycles returns the new value (RAM ordering).
//  - Reset values: state=LOAD, starve_cnt=0, i_rvalid=d_rvalid=0, phase_run=0; all grants,
//    ram_en, ram_we, core_stall are 0 while rst=1 regardless of requests.
//  - rst mid-operation: pending rvalid of the cycle after rst is 0; returns to LOAD.
//  - ld_req and ld_done in the same cycle: write performed, then RUN next cycle.
// TESTING
//  1 Reset, ld_req writes 0x11..0x14 to addr 0..3, ld_done -> phase_run=1 next cycle; i_req addr 2 in LOAD -> i_gnt=0, core_stall=1.
//  2 RUN, i_req addr 3 alone -> i_gnt same cycle, i_rvalid=1, i_rdata=0x14 next cycle.
//  3 i_req+d_req(read addr 1) together -> d_gnt, fetch stalled; next cycle d_rvalid=1, d_rdata=0x12.
//  4 d_req held continuously with i_req -> fetch denied 4 cycles, granted on 5th; starve_cnt back to 0.
//  5 d_we write 0xDEAD to addr 5, next cycle d read addr 5 -> d_rdata=0xDEAD, d_rvalid only for read.
//  6 Assert rst the cycle after an i_gnt -> i_rvalid=0, state LOAD, all grants 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous single-port RAM between a program loader (LOAD phase)
// and the core fetch/data ports (RUN phase), with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int unsigned AW           = 6,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_done,
    output logic          ld_gnt,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,

    output logic          core_stall,
    output logic          phase_run
);

    localparam int unsigned   SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

    typedef enum logic {StLoad, StRun} state_e;

    state_e        state_q;
    logic [SW-1:0] starve_q;
    logic          i_rvalid_q;
    logic          d_rvalid_q;

    logic          in_load;
    logic          in_run;
    logic          fetch_first;

    // Grants are forced low while rst is high, independent of the registered state.
    always_comb begin
        in_load     = (state_q == StLoad) && !rst;
        in_run      = (state_q == StRun) && !rst;
        fetch_first = (starve_q == StarveMax);

        ld_gnt = in_load && ld_req;
        i_gnt  = in_run && i_req && (!d_req || fetch_first);
        d_gnt  = in_run && d_req && !(i_req && fetch_first);

        core_stall = !rst && ((i_req && !i_gnt) || (d_req && !d_gnt));
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (ld_gnt) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
        end else if (i_gnt) begin
            ram_en   = 1'b1;
            ram_addr = i_addr;
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            starve_q   <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            if (state_q == StLoad && ld_done) begin
                state_q <= StRun;
            end

            // Counts consecutive cycles a live fetch request lost to data.
            if (state_q != StRun || i_gnt || !i_req) begin
                starve_q <= '0;
            end else if (starve_q != StarveMax) begin
                starve_q <= starve_q + SW'(1);
            end

            i_rvalid_q <= i_gnt;
            d_rvalid_q <= d_gnt && !d_we;
        end
    end

    assign phase_run = (state_q == StRun);
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// RUN-phase traffic checked against a behavioural arbitration and memory model.
module tb_mem_port_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, ld_done, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          core_stall, phase_run;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_done   (ld_done),
        .ld_gnt    (ld_gnt),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .core_stall(core_stall),
        .phase_run (phase_run)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic idle_inputs();
        ld_req = 0; ld_done = 0; ld_addr = '0; ld_wdata = '0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        ld_req = 1; i_req = 1; d_req = 1; d_we = 1;
        #1;
        checks++;
        if ({ld_gnt, i_gnt, d_gnt, ram_en, ram_we, core_stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_grants: got %b, want 000000",
                     {ld_gnt, i_gnt, d_gnt, ram_en, ram_we, core_stall});
        end
        checks++;
        if ({phase_run, i_rvalid, d_rvalid} !== 3'b0) begin
            errors++;
            $display("FAIL reset_regs: got %b, want 000", {phase_run, i_rvalid, d_rvalid});
        end
        @(negedge clk);
        idle_inputs();
        rst = 0;
    endtask

    // Fill the whole RAM; last write coincides with ld_done.
    task automatic test_load();
        for (int k = 0; k < 64; k++) begin
            logic [DW-1:0] w;
            @(negedge clk);
            checks++;
            if (phase_run !== 1'b0) begin
                errors++;
                $display("FAIL load_phase: phase_run got %b, want 0 (k=%0d)", phase_run, k);
            end
            w = (k < 4) ? DW'(32'h11 + k) : $urandom;
            ref_mem[k] = w;
            ld_req = 1; ld_addr = AW'(k); ld_wdata = w; ld_done = (k == 63);
            i_req = (k == 2); i_addr = 6'd2;
            #1;
            checks++;
            if (ld_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 ||
                ram_addr !== AW'(k) || ram_wdata !== w) begin
                errors++;
                $display("FAIL load_write: gnt/en/we=%b%b%b addr=%0d data=%h, want 111 %0d %h",
                         ld_gnt, ram_en, ram_we, ram_addr, ram_wdata, k, w);
            end
            if (k == 2) begin
                checks++;
                if (i_gnt !== 1'b0 || core_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL load_fetch_stall: i_gnt=%b core_stall=%b, want 0 1",
                             i_gnt, core_stall);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (phase_run !== 1'b1) begin
            errors++;
            $display("FAIL enter_run: phase_run got %b, want 1", phase_run);
        end
        // Loader activity in RUN is ignored.
        ld_req = 1; ld_done = 1; ld_wdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (ld_gnt !== 1'b0 || ram_en !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL run_loader_ignored: ld_gnt=%b ram_en=%b stall=%b, want 0 0 0",
                     ld_gnt, ram_en, core_stall);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (phase_run !== 1'b1) begin
            errors++;
            $display("FAIL run_terminal: phase_run got %b, want 1", phase_run);
        end
    endtask

    task automatic test_fetch_alone();
        @(negedge clk);
        i_req = 1; i_addr = 6'd3;
        #1;
        checks++;
        if ({i_gnt, d_gnt, core_stall, ram_en, ram_we} !== 5'b10010 || ram_addr !== 6'd3) begin
            errors++;
            $display("FAIL fetch_grant: gnt/stall/en/we=%b addr=%0d, want 10010 3",
                     {i_gnt, d_gnt, core_stall, ram_en, ram_we}, ram_addr);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'h14) begin
            errors++;
            $display("FAIL fetch_data: i_rvalid=%b d_rvalid=%b i_rdata=%h, want 1 0 00000014",
                     i_rvalid, d_rvalid, i_rdata);
        end
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid_pulse: i_rvalid got %b, want 0", i_rvalid);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        i_req = 1; i_addr = 6'd0; d_req = 1; d_we = 0; d_addr = 6'd1;
        #1;
        checks++;
        if ({i_gnt, d_gnt, core_stall} !== 3'b011) begin
            errors++;
            $display("FAIL data_priority: i_gnt/d_gnt/stall got %b, want 011",
                     {i_gnt, d_gnt, core_stall});
        end
        @(negedge clk);
        d_req = 0;
        checks++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'h12) begin
            errors++;
            $display("FAIL data_read: d_rvalid=%b i_rvalid=%b d_rdata=%h, want 1 0 00000012",
                     d_rvalid, i_rvalid, d_rdata);
        end
        #1;
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL fetch_after_data: i_gnt got %b, want 1", i_gnt);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h11) begin
            errors++;
            $display("FAIL fetch_after_data_rd: i_rvalid=%b i_rdata=%h, want 1 00000011",
                     i_rvalid, i_rdata);
        end
    endtask

    // Two starvation windows back to back: grant on attempt 5 and again on 10.
    task automatic test_starvation();
        logic          prev_i = 0, prev_d = 0;
        logic [AW-1:0] prev_da = '0;
        for (int c = 1; c <= 11; c++) begin
            logic exp_i;
            @(negedge clk);
            checks++;
            if (i_rvalid !== prev_i || d_rvalid !== prev_d ||
                (prev_d && d_rdata !== ref_mem[prev_da]) || (prev_i && i_rdata !== ref_mem[7])) begin
                errors++;
                $display("FAIL starve_rvalid: c=%0d i_rvalid=%b d_rvalid=%b rdata=%h, want %b %b",
                         c, i_rvalid, d_rvalid, d_rdata, prev_i, prev_d);
            end
            if (c == 11) break;
            i_req = 1; i_addr = 6'd7; d_req = 1; d_we = 0; d_addr = AW'(8 + c);
            exp_i = (c == 5 || c == 10);
            #1;
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i || core_stall !== 1'b1) begin
                errors++;
                $display("FAIL starve_c%0d: i_gnt=%b d_gnt=%b stall=%b, want %b %b 1",
                         c, i_gnt, d_gnt, core_stall, exp_i, !exp_i);
            end
            prev_i = exp_i; prev_d = !exp_i; prev_da = AW'(8 + c);
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 6'd5; d_wdata = 32'hDEAD;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 6'd5 || ram_wdata !== 32'hDEAD) begin
            errors++;
            $display("FAIL data_write: d_gnt=%b we=%b addr=%0d wdata=%h, want 1 1 5 0000dead",
                     d_gnt, ram_we, ram_addr, ram_wdata);
        end
        ref_mem[5] = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid: d_rvalid got %b, want 0", d_rvalid);
        end
        d_we = 0;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD) begin
            errors++;
            $display("FAIL write_then_read: d_rvalid=%b d_rdata=%h, want 1 0000dead",
                     d_rvalid, d_rdata);
        end
    endtask

    // Random requesters that hold until granted; model tracks grants, wait streak and memory.
    task automatic test_random();
        logic          i_pend = 0, d_pend = 0, d_we_v = 0;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] dw = '0;
        logic          pi = 0, pd = 0;
        logic [DW-1:0] pi_data = '0, pd_data = '0;
        int            fetch_wait = 0;
        for (int n = 0; n <= 400; n++) begin
            logic e_i, e_d, e_stall, e_en, e_we;
            logic [AW-1:0] e_addr;
            @(negedge clk);
            checks++;
            if (i_rvalid !== pi || d_rvalid !== pd || (pi && i_rdata !== pi_data) ||
                (pd && d_rdata !== pd_data)) begin
                errors++;
                $display("FAIL rand_rvalid n=%0d: i %b/%h d %b/%h, want i %b/%h d %b/%h", n,
                         i_rvalid, i_rdata, d_rvalid, d_rdata, pi, pi_data, pd, pd_data);
            end
            if (n == 400) break;
            if (!i_pend && $urandom_range(0, 3) != 0) begin
                i_pend = 1; ia = AW'($urandom_range(0, 63));
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1; da = AW'($urandom_range(0, 63));
                d_we_v = $urandom_range(0, 1) == 1; dw = $urandom;
            end
            i_req = i_pend; i_addr = ia;
            d_req = d_pend; d_addr = da; d_we = d_we_v; d_wdata = dw;
            e_i     = i_pend && (!d_pend || fetch_wait >= LIMIT);
            e_d     = d_pend && !e_i;
            e_stall = (i_pend && !e_i) || (d_pend && !e_d);
            e_en    = e_i || e_d;
            e_we    = e_d && d_we_v;
            e_addr  = e_i ? ia : da;
            #1;
            checks++;
            if ({i_gnt, d_gnt, core_stall} !== {e_i, e_d, e_stall} || ram_en !== e_en ||
                ram_we !== e_we || (e_en && ram_addr !== e_addr) ||
                (e_we && ram_wdata !== dw)) begin
                errors++;
                $display("FAIL rand_grant n=%0d: gnt/stall=%b en/we=%b%b addr=%0d, want %b %b%b %0d",
                         n, {i_gnt, d_gnt, core_stall}, ram_en, ram_we, ram_addr,
                         {e_i, e_d, e_stall}, e_en, e_we, e_addr);
            end
            pi = e_i; pi_data = ref_mem[ia];
            pd = e_d && !d_we_v; pd_data = ref_mem[da];
            if (e_d && d_we_v) ref_mem[da] = dw;
            fetch_wait = (i_pend && !e_i) ? fetch_wait + 1 : 0;
            if (e_i) i_pend = 0;
            if (e_d) d_pend = 0;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i_req = 1; i_addr = 6'd3;
        #1;
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_gnt: i_gnt got %b, want 1", i_gnt);
        end
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({i_gnt, d_gnt, ld_gnt, ram_en, core_stall} !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst_grants: got %b, want 00000",
                     {i_gnt, d_gnt, ld_gnt, ram_en, core_stall});
        end
        @(negedge clk);
        rst = 0;
        checks++;
        if (i_rvalid !== 1'b0 || phase_run !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_state: i_rvalid=%b phase_run=%b, want 0 0",
                     i_rvalid, phase_run);
        end
        #1;
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || core_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_load: i_gnt=%b d_gnt=%b stall=%b, want 0 0 1",
                     i_gnt, d_gnt, core_stall);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch_alone();
        test_priority();
        test_starvation();
        test_write_read();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
